player_powerup_timer: RTL and testbench
=======================================

Name: player_powerup_timer

Overview:
- Upstream source of the player status flags `player_is_invincible` and `player_is_speedy` consumed by the player pixel colouring stage.
- Converts single-cycle pickup and hit events from game logic into timed status flags.
- Issues a one-cycle damage pulse when a hit lands on an unprotected player.
- Adds a post-hit grace period and an expiry warning flag for blink effects.

Parameters:
- TICKS_PER_SEC, 100_000_000, clock cycles per second.
- INVINC_SEC, 5, invincibility power-up duration in seconds.
- SPEEDY_SEC, 5, speed power-up duration in seconds.
- GRACE_SEC, 1, post-hit invulnerability duration in seconds.
- WARN_TICKS, 100_000_000, cycles before expiry during which `powerup_expiring` is asserted.

Ports:
- clock_100mhz  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- game_active  in  1  high while a round is in play
- pickup_invincible  in  1  one-cycle pulse: invincibility collected
- pickup_speedy  in  1  one-cycle pulse: speed collected
- player_hit  in  1  one-cycle pulse: collision with a hazard
- player_is_invincible  out  1  high in POWERED or GRACE
- player_is_speedy  out  1  high while the speed effect is active
- player_damage  out  1  one-cycle pulse: hit accepted
- powerup_expiring  out  1  an effect is in its final WARN_TICKS cycles

Behaviour:
- All outputs are registered.
- Reset: when `reset_n` = 0 at a clock edge, both FSMs go to IDLE, all counters clear to 0, and all outputs are 0.
- `game_active` = 0 forces the same state as reset every cycle. Pickups and hits are ignored while it is low.
- Derived durations:
  - N_INV = INVINC_SEC*TICKS_PER_SEC
  - N_SPD = SPEEDY_SEC*TICKS_PER_SEC
  - N_GR = GRACE_SEC*TICKS_PER_SEC
- Counter width: clog2(max(N_INV, N_SPD, N_GR)+1) bits, which is 29 bits at the defaults.
- Invincibility FSM, states IDLE, POWERED, GRACE, with one down-counter `inv_cnt`:
  - pickup_invincible in any state: go to POWERED and load `inv_cnt` = N_INV-1. This restarts the effect; there is no stacking.
  - player_hit in IDLE with no same-cycle pickup_invincible: go to GRACE, load `inv_cnt` = N_GR-1, and pulse `player_damage` high for exactly one cycle on the next edge.
  - player_hit in POWERED or GRACE: ignored, no damage.
  - POWERED or GRACE with `inv_cnt` = 0 and no pickup: go to IDLE. Otherwise decrement `inv_cnt`.
- Resulting flag timing:
  - `player_is_invincible` rises on the edge after the pickup and stays high for exactly N_INV cycles (N_GR cycles for grace).
  - A pickup during GRACE converts it to a full POWERED period.
- Speed FSM, states IDLE, ACTIVE, with `spd_cnt`:
  - pickup_speedy: go to ACTIVE and load `spd_cnt` = N_SPD-1.
  - Decrement each cycle; leave ACTIVE at 0. `player_is_speedy` is high for exactly N_SPD cycles.
- An accepted hit (one that produces `player_damage`) forces the speed FSM to IDLE. This overrides a same-cycle pickup_speedy.
- A rejected hit leaves the speed effect untouched.
- Simultaneous pickup_invincible and player_hit: the pickup wins, and there is no damage in any state.
- `powerup_expiring` = (POWERED and `inv_cnt` < WARN_TICKS) or (ACTIVE and `spd_cnt` < WARN_TICKS).
  - GRACE never asserts it.
  - It is registered, aligned with the flags, and drops on the same edge as the corresponding flag.
- `game_active` falling mid-effect: flags clear on the next edge. No effect resumes when `game_active` rises again.

Test Plan:
All scenarios use TICKS_PER_SEC=10, INVINC_SEC=3, SPEEDY_SEC=2, GRACE_SEC=1, WARN_TICKS=5.
- pickup_invincible pulse at cycle 0 -> `player_is_invincible` high for cycles 1..30 inclusive; `powerup_expiring` high for cycles 26..30; both low at cycle 31.
- player_hit at cycle 0 in IDLE -> `player_damage` high for cycle 1 only; invincible high for cycles 1..10. A second hit at cycle 5 gives no damage. A hit at cycle 12 gives damage at cycle 13.
- pickup_speedy at 0, then pickup_speedy again at 15 -> `player_is_speedy` high for cycles 1..35 (reload, not additive).
- pickup_speedy at 0, player_hit at 4 -> damage at cycle 5, speedy low from cycle 5. Repeating with pickup_invincible at 0 instead gives no damage and speedy stays high through cycle 20.
- pickup_invincible and player_hit in the same cycle from IDLE -> no damage pulse; POWERED for 30 cycles.
- Effects active, `game_active` low at cycle 7 -> all outputs 0 at cycle 8. Pickups while low are ignored. `reset_n` low mid-effect behaves identically.

Source files
------------

// File: rtl/player_powerup_timer_if.sv
// rtl/player_powerup_timer_if.sv - game-event and player-status signal bundle for the power-up timer
interface player_powerup_timer_if;
  logic game_active;
  logic pickup_invincible;
  logic pickup_speedy;
  logic player_hit;
  logic player_is_invincible;
  logic player_is_speedy;
  logic player_damage;
  logic powerup_expiring;

  modport master (
    output game_active, pickup_invincible, pickup_speedy, player_hit,
    input  player_is_invincible, player_is_speedy, player_damage, powerup_expiring
  );

  modport slave (
    input  game_active, pickup_invincible, pickup_speedy, player_hit,
    output player_is_invincible, player_is_speedy, player_damage, powerup_expiring
  );
endinterface

// File: rtl/player_powerup_timer.sv
// rtl/player_powerup_timer.sv - timed invincibility/speed flags, hit damage pulse and expiry warning
module player_powerup_timer #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned INVINC_SEC    = 5,
  parameter int unsigned SPEEDY_SEC    = 5,
  parameter int unsigned GRACE_SEC     = 1,
  parameter int unsigned WARN_TICKS    = 100_000_000
) (
  input  logic                 clock_100mhz,
  input  logic                 reset_n,
  player_powerup_timer_if.slave bus
);

  localparam int unsigned N_INV = INVINC_SEC * TICKS_PER_SEC;
  localparam int unsigned N_SPD = SPEEDY_SEC * TICKS_PER_SEC;
  localparam int unsigned N_GR  = GRACE_SEC * TICKS_PER_SEC;
  localparam int unsigned N_MAX = (N_INV > N_SPD) ? ((N_INV > N_GR) ? N_INV : N_GR)
                                                  : ((N_SPD > N_GR) ? N_SPD : N_GR);
  localparam int CNT_W = $clog2(N_MAX + 1);

  typedef enum logic [1:0] {INV_IDLE, INV_POWERED, INV_GRACE} inv_state_t;
  typedef enum logic {SPD_IDLE, SPD_ACTIVE} spd_state_t;

  inv_state_t       inv_state, inv_state_nxt;
  spd_state_t       spd_state, spd_state_nxt;
  logic [CNT_W-1:0] inv_cnt, inv_cnt_nxt;
  logic [CNT_W-1:0] spd_cnt, spd_cnt_nxt;
  logic             hit_accept;
  logic             expiring_nxt;

  // A pickup in the same cycle always beats a hit, so damage needs both IDLE and no pickup.
  always_comb begin
    hit_accept    = bus.player_hit && !bus.pickup_invincible && (inv_state == INV_IDLE);
    inv_state_nxt = inv_state;
    inv_cnt_nxt   = inv_cnt;
    spd_state_nxt = spd_state;
    spd_cnt_nxt   = spd_cnt;

    if (bus.pickup_invincible) begin
      inv_state_nxt = INV_POWERED;
      inv_cnt_nxt   = CNT_W'(N_INV - 1);
    end else begin
      case (inv_state)
        INV_IDLE: begin
          if (hit_accept) begin
            inv_state_nxt = INV_GRACE;
            inv_cnt_nxt   = CNT_W'(N_GR - 1);
          end
        end
        INV_POWERED, INV_GRACE: begin
          if (inv_cnt == '0) inv_state_nxt = INV_IDLE;
          else               inv_cnt_nxt   = inv_cnt - CNT_W'(1);
        end
        default: begin
          inv_state_nxt = INV_IDLE;
          inv_cnt_nxt   = '0;
        end
      endcase
    end

    if (hit_accept) begin
      spd_state_nxt = SPD_IDLE;
      spd_cnt_nxt   = '0;
    end else if (bus.pickup_speedy) begin
      spd_state_nxt = SPD_ACTIVE;
      spd_cnt_nxt   = CNT_W'(N_SPD - 1);
    end else if (spd_state == SPD_ACTIVE) begin
      if (spd_cnt == '0) spd_state_nxt = SPD_IDLE;
      else               spd_cnt_nxt   = spd_cnt - CNT_W'(1);
    end

    // Warning is computed from next state so it lines up with the registered flags.
    expiring_nxt = ((inv_state_nxt == INV_POWERED) && (32'(inv_cnt_nxt) < WARN_TICKS)) ||
                   ((spd_state_nxt == SPD_ACTIVE)  && (32'(spd_cnt_nxt) < WARN_TICKS));
  end

  always_ff @(posedge clock_100mhz) begin
    if (!reset_n || !bus.game_active) begin
      inv_state                <= INV_IDLE;
      spd_state                <= SPD_IDLE;
      inv_cnt                  <= '0;
      spd_cnt                  <= '0;
      bus.player_is_invincible <= 1'b0;
      bus.player_is_speedy     <= 1'b0;
      bus.player_damage        <= 1'b0;
      bus.powerup_expiring     <= 1'b0;
    end else begin
      inv_state                <= inv_state_nxt;
      spd_state                <= spd_state_nxt;
      inv_cnt                  <= inv_cnt_nxt;
      spd_cnt                  <= spd_cnt_nxt;
      bus.player_is_invincible <= (inv_state_nxt != INV_IDLE);
      bus.player_is_speedy     <= (spd_state_nxt == SPD_ACTIVE);
      bus.player_damage        <= hit_accept;
      bus.powerup_expiring     <= expiring_nxt;
    end
  end

endmodule

// File: tb/tb_player_powerup_timer.sv
// tb/tb_player_powerup_timer.sv - directed self-checking bench for player_powerup_timer
module tb_player_powerup_timer;

  logic clock_100mhz = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  player_powerup_timer_if bus();

  player_powerup_timer #(
    .TICKS_PER_SEC(10),
    .INVINC_SEC   (3),
    .SPEEDY_SEC   (2),
    .GRACE_SEC    (1),
    .WARN_TICKS   (5)
  ) dut (
    .clock_100mhz(clock_100mhz),
    .reset_n     (reset_n),
    .bus         (bus)
  );

  always #5 clock_100mhz = ~clock_100mhz;

  task automatic check(input string tag, input int cyc, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int cyc,
                            input logic inv, input logic spd, input logic dmg, input logic exp);
    check({tag, ".invincible"}, cyc, bus.player_is_invincible, inv);
    check({tag, ".speedy"},     cyc, bus.player_is_speedy,     spd);
    check({tag, ".damage"},     cyc, bus.player_damage,        dmg);
    check({tag, ".expiring"},   cyc, bus.powerup_expiring,     exp);
  endtask

  // Apply inputs for one cycle, cross the edge, clear pulses, settle away from the edge.
  task automatic step(input logic ga, input logic rn, input logic pi, input logic ps, input logic ph);
    bus.game_active       = ga;
    reset_n               = rn;
    bus.pickup_invincible = pi;
    bus.pickup_speedy     = ps;
    bus.player_hit        = ph;
    @(posedge clock_100mhz);
    #1;
    bus.pickup_invincible = 1'b0;
    bus.pickup_speedy     = 1'b0;
    bus.player_hit        = 1'b0;
  endtask

  task automatic clear_state();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int k;
    bus.game_active       = 1'b1;
    bus.pickup_invincible = 1'b0;
    bus.pickup_speedy     = 1'b0;
    bus.player_hit        = 1'b0;
    reset_n               = 1'b0;
    #2;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Invincibility pickup at cycle 0: high 1..30, warning 26..30.
    for (int c = 0; c <= 31; c++) begin
      step(1'b1, 1'b1, c == 0, 1'b0, 1'b0);
      k = c + 1;
      check_outs("inv_pickup", k, (k >= 1 && k <= 30), 1'b0, 1'b0, (k >= 26 && k <= 30));
    end

    // Hits at 0, 5, 12: damage at 1 and 13, grace 1..10 and 13..22.
    clear_state();
    for (int c = 0; c <= 23; c++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, (c == 0 || c == 5 || c == 12));
      k = c + 1;
      check_outs("grace", k, ((k >= 1 && k <= 10) || (k >= 13 && k <= 22)), 1'b0,
                 (k == 1 || k == 13), 1'b0);
    end

    // Speed pickups at 0 and 15: reload, high 1..35, warning 31..35.
    clear_state();
    for (int c = 0; c <= 36; c++) begin
      step(1'b1, 1'b1, 1'b0, (c == 0 || c == 15), 1'b0);
      k = c + 1;
      check_outs("spd_reload", k, 1'b0, (k >= 1 && k <= 35), 1'b0, (k >= 31 && k <= 35));
    end

    // Speed at 0, accepted hit at 4: damage at 5 cancels speed, grace 5..14.
    clear_state();
    for (int c = 0; c <= 15; c++) begin
      step(1'b1, 1'b1, 1'b0, c == 0, c == 4);
      k = c + 1;
      check_outs("spd_hit", k, (k >= 5 && k <= 14), (k >= 1 && k <= 4), k == 5, 1'b0);
    end

    // Speed and invincibility at 0, hit at 4 is rejected: speed runs 1..20.
    clear_state();
    for (int c = 0; c <= 31; c++) begin
      step(1'b1, 1'b1, c == 0, c == 0, c == 4);
      k = c + 1;
      check_outs("spd_protected", k, (k >= 1 && k <= 30), (k >= 1 && k <= 20), 1'b0,
                 ((k >= 16 && k <= 20) || (k >= 26 && k <= 30)));
    end

    // Simultaneous pickup and hit from IDLE: pickup wins, no damage.
    clear_state();
    for (int c = 0; c <= 31; c++) begin
      step(1'b1, 1'b1, c == 0, 1'b0, c == 0);
      k = c + 1;
      check_outs("pickup_vs_hit", k, (k >= 1 && k <= 30), 1'b0, 1'b0, (k >= 26 && k <= 30));
    end

    // game_active low at 7..9 with a pickup at 8: everything clears at 8 and stays clear.
    clear_state();
    for (int c = 0; c <= 12; c++) begin
      step(!(c >= 7 && c <= 9), 1'b1, (c == 0 || c == 8), (c == 0 || c == 8), 1'b0);
      k = c + 1;
      check_outs("game_off", k, (k <= 7), (k <= 7), 1'b0, 1'b0);
    end

    // reset_n low at 7..9 with a pickup at 8 behaves identically.
    clear_state();
    for (int c = 0; c <= 12; c++) begin
      step(1'b1, !(c >= 7 && c <= 9), (c == 0 || c == 8), (c == 0 || c == 8), 1'b0);
      k = c + 1;
      check_outs("reset_mid", k, (k <= 7), (k <= 7), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
